// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// State encoding, PC step and default reset/halt constants live here.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_perf.sv
// Fetch performance counters: instructions delivered and cycles spent
// waiting on the memory responder. Both wrap modulo 2^32.
module ifetch_perf
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_fetch,
    input  logic        count_wait,
    output logic [31:0] fetch_count,
    output logic [31:0] wait_count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
            wait_count  <= 32'd0;
        end else begin
            if (count_fetch) fetch_count <= fetch_count + 32'd1;
            if (count_wait)  wait_count  <= wait_count + 32'd1;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding fetch, a single-entry
// instruction holding register, redirect and halt. Optional counters via IFETCH_PERF_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | request outstanding at PC, waiting for MemReady
// ST_VALID | Instr/InstrPC presented to decode until accepted
// ST_HALT  | halt word seen, fetching stopped until Redirect
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        CLK,
    input  logic        ResetN,
    output logic [31:0] MemA,
    output logic        MemReq,
    input  logic        MemReady,
    input  logic [31:0] MemRD,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        Halted
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] WaitCount
`endif
);

    fetch_state_t state;
    logic [31:0]  pc;

    assign MemA = pc;

    // Redirect takes priority over everything, including a same-cycle MemReady.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state      <= ST_FETCH;
            pc         <= word_align(RESET_PC);
            MemReq     <= 1'b1;
            InstrValid <= 1'b0;
            Instr      <= 32'd0;
            InstrPC    <= 32'd0;
            Halted     <= 1'b0;
        end else if (Redirect) begin
            state      <= ST_FETCH;
            pc         <= word_align(RedirectPC);
            MemReq     <= 1'b1;
            InstrValid <= 1'b0;
            Halted     <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (MemReady) begin
                        if (MemRD == HALT_WORD) begin
                            state  <= ST_HALT;
                            MemReq <= 1'b0;
                            Halted <= 1'b1;
                        end else begin
                            state      <= ST_VALID;
                            Instr      <= MemRD;
                            InstrPC    <= pc;
                            pc         <= pc + PC_STEP;
                            MemReq     <= 1'b0;
                            InstrValid <= 1'b1;
                        end
                    end
                end
                ST_VALID: begin
                    if (!Stall) begin
                        state      <= ST_FETCH;
                        MemReq     <= 1'b1;
                        InstrValid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state      <= ST_FETCH;
                    MemReq     <= 1'b1;
                    InstrValid <= 1'b0;
                    Halted     <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic count_fetch;
    logic count_wait;

    assign count_fetch = (state == ST_FETCH) && MemReady && !Redirect
                         && (MemRD != HALT_WORD);
    assign count_wait  = (state == ST_FETCH) && !MemReady;

    ifetch_perf u_perf (
        .clk         (CLK),
        .rst_n       (ResetN),
        .count_fetch (count_fetch),
        .count_wait  (count_wait),
        .fetch_count (FetchCount),
        .wait_count  (WaitCount)
    );
`endif

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset; bits [1:0] SHALL be treated as 0.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, is the instruction encoding that stops fetching.
REQ-003 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-004 ResetN  input  1  asynchronous, active-low reset.
REQ-005 MemA  output  32  instruction address to the memory responder; equals PC in every state.
REQ-006 MemReq  output  1  high while a fetch is outstanding.
REQ-007 MemReady  input  1  responder strobe; MemRD is valid only in a cycle with MemReady=1.
REQ-008 MemRD  input  32  instruction word for MemA.
REQ-009 Stall  input  1  decode stage cannot accept this cycle.
REQ-010 Redirect  input  1  branch/jump taken; load RedirectPC.
REQ-011 RedirectPC  input  32  new fetch address.
REQ-012 InstrValid  output  1  Instr/InstrPC hold a valid instruction.
REQ-013 Instr  output  32  fetched instruction word.
REQ-014 InstrPC  output  32  address Instr was fetched from.
REQ-015 Halted  output  1  high in HALT state.

Function
REQ-016 FSM states FETCH, VALID, HALT; registered outputs only, no combinational path from MemRD to Instr.
REQ-017 FETCH: MemReq=1, InstrValid=0; MemA SHALL stay stable until MemReady.
REQ-018 FETCH with MemReady=1, Redirect=0, MemRD!=HALT_WORD: Instr<=MemRD, InstrPC<=PC, PC<=PC+4, next state VALID.
REQ-019 FETCH with MemReady=1, Redirect=0, MemRD==HALT_WORD: next state HALT; PC and Instr unchanged; word not presented.
REQ-020 VALID: MemReq=0, InstrValid=1; Instr/InstrPC held; transfer occurs when InstrValid=1 and Stall=0; next state FETCH.
REQ-021 VALID with Stall=1: remain, outputs unchanged; MemReady is ignored in VALID.
REQ-022 HALT: MemReq=0, InstrValid=0, Halted=1; leave only via Redirect.
REQ-023 Redirect=1 in any state: PC<={RedirectPC[31:2],2'b00}, InstrValid<=0, next state FETCH; pending Instr dropped even if Stall=0 that cycle.
REQ-024 Redirect and MemReady in the same cycle: Redirect wins, MemRD discarded.
REQ-025 PC increment wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-026 Latency: MemReady in FETCH -> InstrValid=1 next cycle; accept -> MemReq=1 next cycle.

Reset
REQ-027 ResetN=0 asynchronously forces: state FETCH, PC=RESET_PC, MemReq=1 once released, InstrValid=0, Instr=0, InstrPC=0, Halted=0.
REQ-028 Reset asserted mid-fetch or in VALID SHALL discard all in-flight data; first post-reset fetch is at RESET_PC.

Configuration
REQ-029 Macro IFETCH_PERF_EN: when defined, outputs FetchCount[31:0] (increments per instruction entering VALID) and WaitCount[31:0] (increments per cycle in FETCH with MemReady=0); both reset to 0, wrap at 2^32.
REQ-030 Without IFETCH_PERF_EN the ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package ifetch_pkg holds state encoding typedef, PC_STEP=4, default HALT_WORD.
REQ-032 Counters are sub-module ifetch_perf, instantiated only under IFETCH_PERF_EN.

Verification
REQ-033 Reset, RESET_PC=0, responder Ready every 4th cycle with RAM[0..2]=0x20080005,0x20090007,0x01095020, Stall=0 -> Instr sequence with InstrPC 0,4,8; MemA stable across each wait.
REQ-034 Stall=1 for 6 cycles while InstrValid=1 -> Instr/InstrPC unchanged, MemReq=0, one transfer after Stall drops.
REQ-035 Redirect=1, RedirectPC=0x0000_0043 same cycle as MemReady -> data dropped, next MemA=0x0000_0040, InstrValid=0.
REQ-036 MemRD=0xFFFF_FFFF at PC 0x0C -> Halted=1, MemReq=0, no InstrValid; Redirect to 0x0 -> fetch resumes at 0x0.
REQ-037 PC=0xFFFF_FFFC fetch -> InstrPC=0xFFFF_FFFC, next MemA=0x0000_0000.
REQ-038 ResetN pulsed low asynchronously in VALID -> InstrValid=0 immediately; with IFETCH_PERF_EN, FetchCount=0 and WaitCount counts 3 per 4-cycle fetch.
